// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised, glitch-filtered SCL/SDA, 11-bit frame decoder
// with odd-parity/stop checks and timeout, feeding a first-word fall-through FIFO.
module ps2_rx_fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                               CLOCK,
    input  logic                               RESET,
    input  logic                               SCL,
    input  logic                               SDA,
    output logic [DATA_WIDTH-1:0]              RX_data,
    output logic                               RX_valid,
    input  logic                               RX_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    FIFO_count,
    output logic                               PARITY_err,
    output logic                               FRAME_err,
    output logic                               OVERFLOW
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Input conditioning: bit 0 carries SCL, bit 1 carries SDA
    logic [1:0]    w_pin;
    logic [1:0]    r_s1, r_s2, r_filt;
    logic [FW-1:0] r_fcnt [2];
    logic          r_scl_d, r_fall;
    logic          w_sda;

    assign w_pin = {SDA, SCL};
    assign w_sda = r_filt[1];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_s1    <= '1;
            r_s2    <= '1;
            r_filt  <= '1;
            r_scl_d <= 1'b1;
            r_fall  <= 1'b0;
            for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
        end else begin
            r_s1    <= w_pin;
            r_s2    <= r_s1;
            r_scl_d <= r_filt[0];
            r_fall  <= r_scl_d & ~r_filt[0];
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    r_filt[i] <= r_s2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 1'b1;
                end
            end
        end
    end

    // Frame decoder
    state_t                r_state, w_state_nxt;
    logic [BW-1:0]         r_bit_cnt;
    logic [TW-1:0]         r_timer;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par;
    logic                  w_timeout, w_par_ok, w_push, w_perr, w_ferr;

    assign w_par_ok  = ^{r_shift, r_par};
    assign w_timeout = (r_state != S_IDLE) && !r_fall && (r_timer == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_perr      = 1'b0;
        w_ferr      = 1'b0;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_ferr      = 1'b1;
        end else if (r_fall) begin
            case (r_state)
                S_IDLE:   if (!w_sda) w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == BW'(DATA_WIDTH - 1)) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    w_perr      = !w_par_ok;
                    w_ferr      = !w_sda;
                    w_push      = w_par_ok && w_sda;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_timer   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE || r_fall) r_timer <= '0;
            else                             r_timer <= r_timer + 1'b1;
            if (r_state != S_DATA)  r_bit_cnt <= '0;
            else if (r_fall)        r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (r_fall && r_state == S_DATA)   r_shift <= {w_sda, r_shift[DATA_WIDTH-1:1]};
        if (r_fall && r_state == S_PARITY) r_par   <= w_sda;
    end

    // FIFO: head is read straight from storage so a fresh write shows up one cycle later
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_full, w_pop, w_wr, w_ovf;

    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign RX_valid   = (r_count != '0);
    assign RX_data    = RX_valid ? r_mem[r_rd_ptr] : '0;
    assign FIFO_count = r_count;
    assign w_pop      = RX_valid & RX_ready;
    assign w_wr       = w_push & (!w_full | w_pop);
    assign w_ovf      = w_push & w_full & !w_pop;

    always_ff @(posedge CLOCK) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            PARITY_err <= 1'b0;
            FRAME_err  <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= r_count + CW'(w_wr) - CW'(w_pop);
            PARITY_err <= w_perr;
            FRAME_err  <= w_ferr;
            OVERFLOW   <= w_ovf;
        end
    end
endmodule
